// File: rtl/im_fetch_pkg.sv
// Shared widths and the prefetch entry type for the instruction-fetch front end.
package im_fetch_pkg;

    localparam int IM_AW = 16;
    localparam int IM_DW = 32;

    typedef struct packed {
        logic [IM_AW-1:0] pc;
        logic [IM_DW-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/im_fetch_fifo.sv
// Small synchronous prefetch FIFO of {pc, data} entries.
// Flush beats push and pop. A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo
    import im_fetch_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [PW:0]     r_count;
    logic            w_doPop;
    logic            w_doPush;

    assign full     = (r_count == FULL_CNT);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign head     = r_mem[r_rdPtr];
    assign w_doPop  = pop & ~empty;
    assign w_doPush = push & (~full | w_doPop);

    // Storage carries no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_doPush && !flush && !rst) begin
            r_mem[r_wrPtr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/im_fetch.sv
// Instruction-fetch initiator: sequential word fetch into a prefetch FIFO, with redirect flush.
module im_fetch
    import im_fetch_pkg::*;
#(
    parameter logic [IM_AW-1:0] RESET_PC = 16'h0000,
    parameter int               DEPTH    = 2
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [IM_AW-1:0]   redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [IM_DW-1:0]   inst_data,
    output logic [IM_AW-1:0]   inst_pc,
    output logic               IM_enable,
    output logic [IM_AW-1:0]   IM_address,
    output logic               IM_write,
    output logic [IM_DW-1:0]   IM_in,
    input  logic [IM_DW-1:0]   IM_out
);

    logic [IM_AW-1:0]        r_fetchPc;
    logic                    w_pop;
    logic                    w_space;
    logic                    w_issue;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_count;
    fetch_entry_t            w_head;
    fetch_entry_t            w_wrEntry;

    // inst_valid is masked during reset so nothing is presented before the FIFO clears.
    assign inst_valid = ~rst & (w_count != '0);
    assign w_pop      = inst_valid & inst_ready;
    assign w_space    = ~w_full | w_pop;
    assign w_issue    = ~rst & fetch_en & ~redirect_valid & w_space;

    assign IM_enable  = w_issue;
    assign IM_address = r_fetchPc;
    assign IM_write   = 1'b0;
    assign IM_in      = '0;

    assign inst_data  = w_head.data;
    assign inst_pc    = w_head.pc;

    assign w_wrEntry.pc   = r_fetchPc;
    assign w_wrEntry.data = IM_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetchPc <= redirect_pc;
        end else if (w_issue) begin
            r_fetchPc <= r_fetchPc + 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_issue),
        .pop      (w_pop & ~w_empty),
        .flush    (redirect_valid),
        .wr_entry (w_wrEntry),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count),
        .head     (w_head)
    );

endmodule

// File: tb/tb_im_fetch.sv
// Self-checking bench for im_fetch: directed scenarios then random traffic against a queue model.
module tb_im_fetch;

    localparam logic [15:0] RESET_PC = 16'h0010;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [15:0] inst_pc;
    logic        IM_enable;
    logic [15:0] IM_address;
    logic        IM_write;
    logic [31:0] IM_in;
    logic [31:0] IM_out;

    int total = 0;
    int bad   = 0;

    logic [15:0] mPc;
    logic [47:0] mQ[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [15:0] a);
        return {16'hA5A5, a};
    endfunction

    // Instruction memory: combinational read of the presented address.
    assign IM_out = memWord(IM_address);

    im_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .IM_enable      (IM_enable),
        .IM_address     (IM_address),
        .IM_write       (IM_write),
        .IM_in          (IM_in),
        .IM_out         (IM_out)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares outputs at the negedge, then advances the model across the next posedge.
    task automatic checkOutput();
        logic expValid, pop, space, issue;
        @(negedge clk);
        expValid = !rst && (mQ.size() > 0);
        pop      = expValid && inst_ready;
        space    = (mQ.size() < DEPTH) || pop;
        issue    = !rst && fetch_en && !redirect_valid && space;
        check("IM_enable",  48'(IM_enable),  48'(issue));
        check("IM_address", 48'(IM_address), 48'(mPc));
        check("inst_valid", 48'(inst_valid), 48'(expValid));
        check("IM_write",   48'(IM_write),   48'(0));
        check("IM_in",      48'(IM_in),      48'(0));
        if (expValid) begin
            check("inst_pc",   48'(inst_pc),   48'(mQ[0][47:32]));
            check("inst_data", 48'(inst_data), 48'(mQ[0][31:0]));
        end
        @(posedge clk);
        if (rst) begin
            mPc = RESET_PC;
            mQ.delete();
        end else if (redirect_valid) begin
            mPc = redirect_pc;
            mQ.delete();
        end else begin
            if (pop) void'(mQ.pop_front());
            if (issue) begin
                mQ.push_back({mPc, memWord(mPc)});
                mPc = mPc + 16'd1;
            end
        end
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic rdy,
                                 input logic rv, input logic [15:0] rpc, input int n);
        rst            = r;
        fetch_en       = en;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        for (int i = 0; i < n; i++) checkOutput();
    endtask

    initial begin
        mPc = RESET_PC;
        rst = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 16'h0;

        $display("[TB] reset and streaming");
        applyStimulus(1, 1, 1, 0, 16'h0, 2);
        applyStimulus(0, 1, 1, 0, 16'h0, 6);

        $display("[TB] decoder stall then release");
        applyStimulus(0, 1, 0, 0, 16'h0, 5);
        applyStimulus(0, 1, 1, 0, 16'h0, 4);

        $display("[TB] redirect while full");
        applyStimulus(0, 1, 0, 0, 16'h0, 3);
        applyStimulus(0, 1, 0, 1, 16'h0200, 1);
        applyStimulus(0, 1, 1, 0, 16'h0, 4);

        $display("[TB] redirect near wrap, then back-to-back redirects");
        applyStimulus(0, 1, 1, 1, 16'hFFFE, 1);
        applyStimulus(0, 1, 1, 0, 16'h0, 6);
        applyStimulus(0, 1, 1, 1, 16'h1234, 1);
        applyStimulus(0, 1, 1, 1, 16'h4321, 1);
        applyStimulus(0, 1, 1, 0, 16'h0, 3);

        $display("[TB] reset mid-stream");
        applyStimulus(0, 1, 0, 0, 16'h0, 3);
        applyStimulus(1, 1, 0, 1, 16'h0777, 1);
        applyStimulus(0, 1, 1, 0, 16'h0, 3);

        $display("[TB] fetch disabled with one entry buffered");
        applyStimulus(0, 0, 1, 0, 16'h0, 4);
        applyStimulus(0, 0, 0, 0, 16'h0, 2);
        applyStimulus(0, 1, 1, 0, 16'h0, 2);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 9) < 8),
                          ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 9) == 0),
                          16'($urandom()),
                          1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
